// File: rtl/switch_debouncer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : switch_debouncer_if                                        |
// | Description : Switch-bus bundle between the board pins, the debouncer    |
// |               and the downstream combinational block.                    |
// |   sw_raw     [WIDTH] raw, asynchronous switch levels from the pins       |
// |   sw_clean   [WIDTH] debounced levels (feeds downstream sw input)        |
// |   sw_changed [1]     one-cycle strobe when any sw_clean bit updates      |
// |   sw_rise    [WIDTH] per-bit 0->1 strobe (SW_DEBOUNCE_EDGE_EN only)      |
// |   sw_fall    [WIDTH] per-bit 1->0 strobe (SW_DEBOUNCE_EDGE_EN only)      |
// |   master : board / test side, drives sw_raw                              |
// |   slave  : debouncer side, drives the conditioned outputs                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface switch_debouncer_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic             sw_changed;
`ifdef SW_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
`endif

`ifdef SW_DEBOUNCE_EDGE_EN
  modport master (
    output sw_raw,
    input  sw_clean,
    input  sw_changed,
    input  sw_rise,
    input  sw_fall
  );

  modport slave (
    input  sw_raw,
    output sw_clean,
    output sw_changed,
    output sw_rise,
    output sw_fall
  );
`else
  modport master (
    output sw_raw,
    input  sw_clean,
    input  sw_changed
  );

  modport slave (
    input  sw_raw,
    output sw_clean,
    output sw_changed
  );
`endif

endinterface
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : switch_debouncer                                           |
// | Description : Two-flop synchroniser plus independent per-bit debounce    |
// |               for the slide-switch bus. A bit's new level is accepted    |
// |               only after the synchronised input has disagreed with the   |
// |               clean output for DEBOUNCE_CYCLES consecutive cycles.       |
// | Ports       :                                                            |
// |   clk    in  system clock, rising edge                                   |
// |   rst_n  in  synchronous active-low reset                                |
// |   bus    switch_debouncer_if.slave                                       |
// |            sw_raw in, sw_clean / sw_changed out                          |
// |            (+ sw_rise / sw_fall out when SW_DEBOUNCE_EDGE_EN)            |
// | Options     : `define SW_DEBOUNCE_EDGE_EN adds per-bit rise/fall strobes |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module switch_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  switch_debouncer_if.slave bus
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1; guarded so a degenerate
  // parameter still yields a legal one-bit vector.
  localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Synchroniser stages: nothing sits between them so the second flop has
  // a full cycle to resolve any metastability of the first.
  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;

  // Debounced state and per-bit stability counters.
  logic [WIDTH-1:0] sw_clean_q, sw_clean_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Bits whose new level is accepted on the coming edge.
  logic [WIDTH-1:0] accept;

  logic             sw_changed_q, sw_changed_d;

`ifdef SW_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] sw_rise_q, sw_rise_d;
  logic [WIDTH-1:0] sw_fall_q, sw_fall_d;
`endif

  // ------------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------------
  always_comb begin
    sync1_d    = bus.sw_raw;
    sync2_d    = sync1_q;
    sw_clean_d = sw_clean_q;
    accept     = '0;

    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] == sw_clean_q[i]) begin
        // Input agrees with output: any partial count (a glitch or a
        // bounce) is thrown away.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        // This is the DEBOUNCE_CYCLES-th consecutive mismatch: accept. The
        // counter returns to 0 here, so it can never pass CNT_MAX.
        accept[i]     = 1'b1;
        sw_clean_d[i] = sync2_q[i];
        cnt_d[i]      = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end

    // Registered strobe so it lines up with the first cycle the new
    // sw_clean is visible; simultaneous bit updates merge into one pulse.
    sw_changed_d = |accept;

`ifdef SW_DEBOUNCE_EDGE_EN
    // The accepted level is the new sw_clean bit, which gives the direction.
    sw_rise_d = accept & sync2_q;
    sw_fall_d = accept & ~sync2_q;
`endif
  end

  // ------------------------------------------------------------------------
  // State registers; reset wins over everything, including a running count.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      sw_clean_q   <= '0;
      sw_changed_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
`ifdef SW_DEBOUNCE_EDGE_EN
      sw_rise_q    <= '0;
      sw_fall_q    <= '0;
`endif
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sw_clean_q   <= sw_clean_d;
      sw_changed_q <= sw_changed_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
`ifdef SW_DEBOUNCE_EDGE_EN
      sw_rise_q    <= sw_rise_d;
      sw_fall_q    <= sw_fall_d;
`endif
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign bus.sw_clean   = sw_clean_q;
  assign bus.sw_changed = sw_changed_q;

`ifdef SW_DEBOUNCE_EDGE_EN
  assign bus.sw_rise    = sw_rise_q;
  assign bus.sw_fall    = sw_fall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_switch_debouncer                                        |
// | Description : Directed self-checking bench for switch_debouncer with     |
// |               DEBOUNCE_CYCLES=4 and a 10 ns clock. Inputs change and     |
// |               outputs are sampled 1 ns after each rising edge; "edge n"  |
// |               is the n-th rising edge after the stimulus change.         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_switch_debouncer;

  localparam int WIDTH = 4;
  localparam int DEB   = 4;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  switch_debouncer_if #(.WIDTH(WIDTH)) bus ();

  switch_debouncer #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    bus.sw_raw = '0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.sw_raw = 4'b1111;
    repeat (3) tick();
    tests_run++;
    if (bus.sw_clean !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_clean: got %b expected 0000", bus.sw_clean);
    end
    tests_run++;
    if (bus.sw_changed !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_changed: got %b expected 0", bus.sw_changed);
    end
`ifdef SW_DEBOUNCE_EDGE_EN
    tests_run++;
    if (bus.sw_rise !== 4'b0000 || bus.sw_fall !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_edges: rise %b fall %b expected 0000/0000", bus.sw_rise, bus.sw_fall);
    end
`endif
  endtask

  // Continues from test_reset: release and step the input together.
  task automatic test_clean_step();
    rst_n      = 1'b1;
    bus.sw_raw = 4'b0101;
    for (int e = 1; e <= 7; e++) begin
      tick();
      tests_run++;
      if (e <= 5 && (bus.sw_clean !== 4'b0000 || bus.sw_changed !== 1'b0)) begin
        tests_failed++;
        $display("FAIL step_wait edge %0d: clean %b changed %b expected 0000/0", e, bus.sw_clean, bus.sw_changed);
      end else if (e == 6 && (bus.sw_clean !== 4'b0101 || bus.sw_changed !== 1'b1)) begin
        tests_failed++;
        $display("FAIL step_accept edge 6: clean %b changed %b expected 0101/1", bus.sw_clean, bus.sw_changed);
      end else if (e == 7 && (bus.sw_clean !== 4'b0101 || bus.sw_changed !== 1'b0)) begin
        tests_failed++;
        $display("FAIL step_after edge 7: clean %b changed %b expected 0101/0", bus.sw_clean, bus.sw_changed);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    bus.sw_raw = 4'b0100;
    repeat (3) tick();
    bus.sw_raw = 4'b0000;
    for (int e = 4; e <= 12; e++) begin
      tick();
      tests_run++;
      if (bus.sw_clean !== 4'b0000 || bus.sw_changed !== 1'b0) begin
        tests_failed++;
        $display("FAIL glitch edge %0d: clean %b changed %b expected 0000/0", e, bus.sw_clean, bus.sw_changed);
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    do_reset();
    pat = 5'b10101;                       // applied LSB first: 1,0,1,0,1
    // Final 0->1 is sampled at edge 5, so the rise lands at edge 10.
    for (int e = 1; e <= 11; e++) begin
      bus.sw_raw = {3'b000, (e <= 5) ? pat[e-1] : 1'b1};
      tick();
      tests_run++;
      if (e < 10 && bus.sw_clean !== 4'b0000) begin
        tests_failed++;
        $display("FAIL bounce_hold edge %0d: clean %b expected 0000", e, bus.sw_clean);
      end else if (e == 10 && (bus.sw_clean !== 4'b0001 || bus.sw_changed !== 1'b1)) begin
        tests_failed++;
        $display("FAIL bounce_accept edge 10: clean %b changed %b expected 0001/1", bus.sw_clean, bus.sw_changed);
      end else if (e == 11 && (bus.sw_clean !== 4'b0001 || bus.sw_changed !== 1'b0)) begin
        tests_failed++;
        $display("FAIL bounce_after edge 11: clean %b changed %b expected 0001/0", bus.sw_clean, bus.sw_changed);
      end
    end
  endtask

  task automatic test_independent();
    logic [3:0] exp_clean [1:9];
    logic       exp_chg   [1:9];
    do_reset();
    for (int e = 1; e <= 9; e++) begin
      exp_clean[e] = (e >= 8) ? 4'b1010 : (e >= 6) ? 4'b1000 : 4'b0000;
      exp_chg[e]   = (e == 6 || e == 8);
    end
    for (int e = 1; e <= 9; e++) begin
      bus.sw_raw = (e >= 3) ? 4'b1010 : 4'b1000;
      tick();
      tests_run++;
      if (bus.sw_clean !== exp_clean[e] || bus.sw_changed !== exp_chg[e]) begin
        tests_failed++;
        $display("FAIL independent edge %0d: clean %b changed %b expected %b/%b", e, bus.sw_clean, bus.sw_changed, exp_clean[e], exp_chg[e]);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    do_reset();
    bus.sw_raw = 4'b1111;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    tests_run++;
    if (bus.sw_clean !== 4'b0000 || bus.sw_changed !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_clear: clean %b changed %b expected 0000/0", bus.sw_clean, bus.sw_changed);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      tests_run++;
      if (e < 6 && bus.sw_clean !== 4'b0000) begin
        tests_failed++;
        $display("FAIL midreset_hold edge %0d: clean %b expected 0000", e, bus.sw_clean);
      end else if (e == 6 && (bus.sw_clean !== 4'b1111 || bus.sw_changed !== 1'b1)) begin
        tests_failed++;
        $display("FAIL midreset_accept edge 6: clean %b changed %b expected 1111/1", bus.sw_clean, bus.sw_changed);
      end
    end
  endtask

  task automatic test_sweep();
    logic [3:0] prev;
    logic [3:0] k4;
    do_reset();
    prev = 4'b0000;
    for (int k = 0; k < 16; k++) begin
      k4         = 4'(k);
      bus.sw_raw = k4;
      for (int e = 1; e <= 10; e++) begin
        tick();
        if (e == 5) begin
          tests_run++;
          if (bus.sw_clean !== prev || bus.sw_changed !== 1'b0) begin
            tests_failed++;
            $display("FAIL sweep_pre k=%0d: clean %b changed %b expected %b/0", k, bus.sw_clean, bus.sw_changed, prev);
          end
        end else if (e == 6) begin
          tests_run++;
          if (bus.sw_clean !== k4 || bus.sw_changed !== (k4 != prev)) begin
            tests_failed++;
            $display("FAIL sweep_accept k=%0d: clean %b changed %b expected %b/%b", k, bus.sw_clean, bus.sw_changed, k4, (k4 != prev));
          end
`ifdef SW_DEBOUNCE_EDGE_EN
          tests_run++;
          if (bus.sw_rise !== (k4 & ~prev) || bus.sw_fall !== (~k4 & prev)) begin
            tests_failed++;
            $display("FAIL sweep_edges k=%0d: rise %b fall %b expected %b/%b", k, bus.sw_rise, bus.sw_fall, (k4 & ~prev), (~k4 & prev));
          end
`endif
        end else if (e == 7) begin
          tests_run++;
          if (bus.sw_changed !== 1'b0) begin
            tests_failed++;
            $display("FAIL sweep_post k=%0d: changed %b expected 0", k, bus.sw_changed);
          end
        end
      end
      prev = k4;
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus.sw_raw   = '0;
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_independent();
    test_reset_mid_count();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
